// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer driving sampler/check/deserializer strobes.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d, presc_q, presc_d, lst_edge, half;
  logic [3:0] bit_q, bit_d;
  logic par_q, par_d, wrap, mid;
  logic strt_q, strt_d, deser_q, deser_d, parc_q, parc_d, stpc_q, stpc_d, dv_q, dv_d;
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    par_d    = par_q;
    dv_d     = 1'b0;
    lst_edge = presc_q - PRESC_W'(1);
    wrap     = (state_q != IDLE) && (edge_q == lst_edge);
    edge_d   = (state_q == IDLE || wrap) ? '0 : edge_q + PRESC_W'(1);
    bit_d    = (state_q == IDLE) ? 4'd0 : wrap ? bit_q + 4'd1 : bit_q;
    case (state_q)
      IDLE: if (!rx_in) begin
        state_d = START;
        presc_d = prescale;
        par_d   = par_en;
      end
      START:  if (wrap) state_d = strt_glitch ? IDLE : DATA;
      DATA:   if (wrap && bit_q == 4'(DATA_WIDTH)) state_d = par_q ? PARITY : STOP;
      PARITY: if (wrap) state_d = par_err ? IDLE : STOP;
      STOP: if (wrap) begin
        state_d = IDLE;
        dv_d    = !stp_err;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      edge_d = '0;
      bit_d  = 4'd0;
    end
    // strobes are registered, so they are decoded from the next-cycle counter values
    half    = presc_d >> 1;
    mid     = edge_d == half + PRESC_W'(2);
    strt_d  = mid && state_d == START;
    deser_d = mid && state_d == DATA;
    parc_d  = mid && state_d == PARITY;
    stpc_d  = mid && state_d == STOP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= 4'd0;
      presc_q <= '0;
      par_q   <= 1'b0;
      strt_q  <= 1'b0;
      deser_q <= 1'b0;
      parc_q  <= 1'b0;
      stpc_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      presc_q <= presc_d;
      par_q   <= par_d;
      strt_q  <= strt_d;
      deser_q <= deser_d;
      parc_q  <= parc_d;
      stpc_q  <= stpc_d;
      dv_q    <= dv_d;
    end
  end
  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign dat_samp_en = state_q != IDLE;
  assign strt_chk_en = strt_q;
  assign deser_en    = deser_q;
  assign par_chk_en  = parc_q;
  assign stp_chk_en  = stpc_q;
  assign data_valid  = dv_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized frame stimulus checked against an arithmetic frame-timing model.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;
  logic clk = 0, rst = 0, rx_in = 1, par_en = 0;
  logic strt_glitch = 0, par_err = 0, stp_err = 0;
  logic [PW-1:0] prescale = 8;
  logic [PW-1:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [PW-1:0] rand_presc();
    return PW'(8 << $urandom_range(0, 2));
  endfunction
  task automatic noise();
    strt_glitch = 1'($urandom);
    par_err     = 1'($urandom);
    stp_err     = 1'($urandom);
  endtask
  task automatic check_idle(input string tag);
    chk({tag, ".edge_cnt"}, edge_cnt, 0);
    chk({tag, ".bit_cnt"}, bit_cnt, 0);
    chk({tag, ".dat_samp_en"}, dat_samp_en, 0);
    chk({tag, ".strobes"}, {strt_chk_en, deser_en, par_chk_en, stp_chk_en}, 0);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check_idle("idle");
      chk("idle.data_valid", data_valid, 0);
      rx_in = 1;
      prescale = rand_presc();
      par_en = 1'($urandom);
      noise();
    end
  endtask
  // Frame model: bit b spans p cycles; strobe at edge p/2+2 of each bit; an error
  // flag only counts at the last edge of its own bit; the frame ends after nb bits.
  task automatic frame(input int p, input int pe, input int g, input int perr, input int serr,
                       input int abort_at);
    int par_bit, stop_bit, nb, e, b;
    logic clean;
    logic [4:0] s;
    par_bit  = DW + 1;
    stop_bit = DW + 1 + pe;
    nb    = g ? 1 : (pe && perr) ? DW + 2 : DW + 2 + pe;
    clean = !g && !(pe && perr) && !serr;
    rx_in = 0;
    prescale = PW'(p);
    par_en = 1'(pe);
    noise();
    for (int t = 0; t <= nb * p; t++) begin
      @(posedge clk); #1;
      if (t < nb * p) begin
        e = t % p;
        b = t / p;
        s = 5'b0;
        if (e == p / 2 + 2)
          s = (b == 0) ? 5'b10000 : (b <= DW) ? 5'b01000 :
              (pe != 0 && b == par_bit) ? 5'b00100 : 5'b00010;
        chk("edge_cnt", edge_cnt, e);
        chk("bit_cnt", bit_cnt, b);
        chk("dat_samp_en", dat_samp_en, 1);
        chk("strobes+dv", {strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}, s);
        rx_in = 1'($urandom);
        prescale = rand_presc();
        par_en = 1'($urandom);
        noise();
        if (e == p - 1 && b == 0) strt_glitch = 1'(g);
        if (e == p - 1 && pe != 0 && b == par_bit) par_err = 1'(perr);
        if (e == p - 1 && b == stop_bit) stp_err = 1'(serr);
        if (b == abort_at && e == 3) begin
          #2 rst = 0;
          #1 check_idle("abort");
          chk("abort.data_valid", data_valid, 0);
          #1 rst = 1;
          rx_in = 1;
          return;
        end
      end else begin
        check_idle("end");
        chk("data_valid", data_valid, clean);
        rx_in = 1;
        noise();
      end
    end
  endtask
  initial begin
    int p, pe;
    #12;
    check_idle("reset");
    chk("reset.data_valid", data_valid, 0);
    @(negedge clk) rst = 1;
    idle(3);
    frame(8, 0, 0, 0, 0, -1);
    idle(2);
    frame(8, 0, 1, 0, 0, -1);
    idle(2);
    frame(16, 1, 0, 1, 0, -1);
    idle(2);
    frame(32, 1, 0, 0, 1, -1);
    frame(32, 1, 0, 0, 0, -1);
    idle(2);
    frame(8, 0, 0, 0, 0, -1);
    frame(8, 0, 0, 0, 0, -1);
    idle(2);
    frame(16, 0, 0, 0, 0, 4);
    idle(5);
    frame(16, 1, 0, 0, 0, -1);
    repeat (12) begin
      p  = 8 << $urandom_range(0, 2);
      pe = int'($urandom_range(0, 1));
      frame(p, pe, int'($urandom_range(0, 4) == 0), int'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3) == 0), -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
